// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: decodes load-use, taken-branch
// and data-memory-wait hazards into register enables/bubbles, with a timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO    = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] TMO_M1 = WW'(MEM_TIMEOUT - 1);

  // Control word order: {pc, ifid, idex, exmem, memwb enables, ifid, idex, memwb flushes}
  localparam logic [7:0] CTL_NORMAL = 8'b11111_000;
  localparam logic [7:0] CTL_MEMSTL = 8'b00000_001;
  localparam logic [7:0] CTL_BRANCH = 8'b11111_110;
  localparam logic [7:0] CTL_LDUSE  = 8'b00111_010;
  localparam logic [7:0] CTL_HALT   = 8'b00000_000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          load_use;
  logic          mem_stall;
  logic [7:0]    release_ctl;
  logic [7:0]    ctl;

  assign load_use  = ex_memread & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mem_stall = mem_req & ~mem_ready;

  // Branch squashes the ID instruction, so it outranks any load-use on it.
  always_comb begin
    if (ex_branch_taken) begin
      release_ctl = CTL_BRANCH;
    end else if (load_use) begin
      release_ctl = CTL_LDUSE;
    end else begin
      release_ctl = CTL_NORMAL;
    end
  end

  always_comb begin
    ctl = CTL_HALT;
    case (state)
      RUN:      ctl = mem_stall ? CTL_MEMSTL : release_ctl;
      MEM_WAIT: ctl = mem_ready ? release_ctl : CTL_MEMSTL;
      ERROR:    ctl = CTL_HALT;
      default:  ctl = CTL_HALT;
    endcase
    if (!rst_n) begin
      ctl = CTL_HALT;
    end else begin
      ctl = ctl;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, memwb_flush} = ctl;

  // The wait cycle spent in RUN counts as the first, so ERROR follows the cycle that
  // brings the count to MEM_TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (mem_stall) begin
            wait_cnt <= WW'(1);
            if (MEM_TIMEOUT <= 1) begin
              state   <= ERROR;
              mem_err <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt < TMO) begin
              wait_cnt <= wait_cnt + WW'(1);
            end
            if (wait_cnt >= TMO_M1) begin
              state   <= ERROR;
              mem_err <= 1'b1;
            end
          end
        end
        ERROR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the load-enable and bubble-insert controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from three hazard sources:

- load-use dependencies;
- taken branches resolved in EX;
- a data-memory wait handshake.

It keeps a timeout watchdog and a stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM wait cycles before error.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a NOP bubble instead of the incoming data.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0.

## Operation
States are RUN, MEM_WAIT and ERROR.

Hazard conditions:
- load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- mem_stall = mem_req & ~mem_ready.

RUN, in priority order:
1. mem_stall:
   - all five enables 0; memwb_flush=1; no other flush.
   - next state MEM_WAIT; wait counter loads 1.
2. ex_branch_taken:
   - all enables 1; ifid_flush=1; idex_flush=1.
   - load_use is ignored because its ID instruction is squashed.
3. load_use:
   - pc_en=0, ifid_en=0; idex_flush=1; exmem_en=1, memwb_en=1.
4. Otherwise: all enables 1, all flushes 0.

MEM_WAIT:
- Outputs are the same as case 1 while mem_ready=0; the wait counter increments each cycle.
- mem_ready=1: outputs are evaluated as in RUN cases 2–4 this cycle, and the next state is RUN.
  - EX and ID contents were frozen, so a deferred branch or load-use is applied now.
- Counter == MEM_TIMEOUT with mem_ready=0: next state ERROR.

ERROR:
- All enables 0, all flushes 0, mem_err=1.
- Exited only by rst_n.

Other rules:
- The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits and never wraps. It reaches MEM_TIMEOUT at most.
- stall_cnt increments on every rising edge where pc_en=0, in any state including ERROR. It saturates at all-ones and does not wrap.
- An enable of 0 with its flush at 1 is legal. Flush is only meaningful when the register loads; for memwb_flush, the MEM/WB register treats flush as a load-NOP override.
- mem_ready without mem_req is ignored.

## Timing
- Reset, while rst_n=0:
  - State is RUN; wait counter and stall_cnt are 0; mem_err=0.
  - All enables and flushes are forced to 0, overriding the combinational decode.
  - Deassertion takes effect at the first rising edge after rst_n goes high.
- Reset mid-operation: assertion immediately forces the reset values, whatever the state (including MEM_WAIT and ERROR).
- Latency:
  - All enable/flush outputs are combinational from the current state and same-cycle inputs (zero cycles).
  - State, counters and mem_err update at the next edge.
- Load-use: exactly 1 stall cycle. On the next cycle the load is in MEM and the hazard clears by itself.
- Taken branch: 1 flush cycle, which squashes 2 wrong-path instructions.
- Memory wait of N cycles, with mem_ready arriving on the (N+1)th cycle of the access:
  - N cycles with pc_en=0.
  - stall_cnt increases by N.
- Timeout: ERROR is entered at the edge ending the MEM_TIMEOUT-th wait cycle; mem_err rises in the following cycle.

## Test plan
- ex_memread=1, ex_rt=5, id_rs=5, no mem_req: for exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. stall_cnt goes 0 -> 1.
- Same as above but ex_rt=0 or id_rt=5 with id_uses_rt=0 (and id_rs≠5): no stall, all enables 1.
- ex_branch_taken=1 together with a load_use match: ifid_flush=idex_flush=1, all enables 1, no stall.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 on cycle 4 with ex_branch_taken=1 held:
  - cycles 1–3: all enables 0, memwb_flush=1.
  - cycle 4: enables 1, ifid_flush=idex_flush=1.
  - stall_cnt=3.
- mem_req=1, mem_ready=0 held with MEM_TIMEOUT=4: ERROR entered after 4 wait cycles; mem_err=1 and enables stay 0 indefinitely. Then rst_n pulse low: mem_err=0, stall_cnt=0, state RUN.
- Assert rst_n=0 asynchronously mid-MEM_WAIT, between clock edges: outputs go to the reset values immediately, without waiting for clk. With CNT_W=4, run 20 stall cycles: stall_cnt saturates at 15.
